// File: rtl/mic1_board_ctrl.sv
// Board-level control for the MIC-1 SoC. Handles power-on reset stretching, push-button
// debouncing, the reset/run/halt/single-step run control and the LED window onto the out word.
module mic1_board_ctrl #(
  parameter int unsigned NUM_BTN         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 6000,
  parameter int unsigned POR_CYCLES      = 63,
  parameter int unsigned STEP_CYCLES     = 1,
  parameter int unsigned RUN_ON_RESET    = 1,
  parameter int unsigned OUT_WIDTH       = 32,
  parameter int unsigned NUM_LED         = 5,
  parameter int unsigned LSB_W           = $clog2(OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BTN-1:0]   btn_n,
  input  logic [OUT_WIDTH-1:0] out_word,
  input  logic [LSB_W-1:0]     led_lsb,
  output logic                 soc_resetn,
  output logic                 run,
  output logic                 halted,
  output logic [NUM_BTN-1:0]   btn_press,
  output logic [NUM_LED-1:0]   led,
  output logic                 ledr_n,
  output logic                 ledg_n
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned POR_W  = $clog2(POR_CYCLES + 1);
  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  // Padded so every window position stays inside the vector; bits past OUT_WIDTH read 0.
  localparam int unsigned EXT_W  = (1 << LSB_W) + NUM_LED;

  typedef enum logic [1:0] {S_RESET, S_RUN, S_HALT, S_STEP} state_t;

  logic [NUM_BTN-1:0] sync1, sync2;
  logic [NUM_BTN-1:0] pressed_sync;
  logic [NUM_BTN-1:0] btn_state;
  logic [DEB_W-1:0]   deb_cnt [NUM_BTN];
  logic [POR_W-1:0]   por_cnt, por_next;
  logic [STEP_W-1:0]  step_cnt;
  state_t             state, state_next;
  logic               run_next, halted_next;
  logic [EXT_W-1:0]   led_ext;

  assign pressed_sync = ~sync2;
  assign led_ext      = EXT_W'(out_word);

  // Two-flop synchroniser on the raw active-low pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Debounce: accepted level flips after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_state <= '0;
      btn_press <= '0;
      for (int b = 0; b < int'(NUM_BTN); b++) deb_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < int'(NUM_BTN); b++) begin
        btn_press[b] <= 1'b0;
        if (pressed_sync[b] == btn_state[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_cnt[b]   <= '0;
          btn_state[b] <= pressed_sync[b];
          btn_press[b] <= pressed_sync[b];
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
        end
      end
    end
  end

  // Power-on reset stretch, restarted while button 0 is held
  always_comb begin
    por_next = por_cnt;
    if (btn_state[0]) begin
      por_next = '0;
    end else if (por_cnt != POR_W'(POR_CYCLES)) begin
      por_next = por_cnt + POR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      por_cnt    <= '0;
      soc_resetn <= 1'b0;
    end else begin
      por_cnt    <= por_next;
      soc_resetn <= (por_next == POR_W'(POR_CYCLES));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= state_next;
  end

  // Run-control next state; SoC reset overrides everything
  always_comb begin
    state_next = state;
    case (state)
      S_RESET: if (soc_resetn) state_next = (RUN_ON_RESET != 0) ? S_RUN : S_HALT;
      S_RUN:   if (btn_press[1]) state_next = S_HALT;
      S_HALT: begin
        if (btn_press[1])      state_next = S_RUN;
        else if (btn_press[2]) state_next = S_STEP;
      end
      S_STEP:  if (step_cnt == '0) state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
    if (!soc_resetn) state_next = S_RESET;
    run_next    = (state_next == S_RUN) || (state_next == S_STEP);
    halted_next = (state_next == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt <= '0;
    end else if (state == S_HALT && state_next == S_STEP) begin
      step_cnt <= STEP_W'(STEP_CYCLES - 1);
    end else if (state == S_STEP && step_cnt != '0) begin
      step_cnt <= step_cnt - STEP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run    <= 1'b0;
      halted <= 1'b0;
      ledr_n <= 1'b0;
      ledg_n <= 1'b1;
      led    <= '0;
    end else begin
      run    <= run_next;
      halted <= halted_next;
      ledr_n <= run_next;
      ledg_n <= ~run_next;
      led    <= led_ext[led_lsb +: NUM_LED];
    end
  end

endmodule

// File: tb/tb_mic1_board_ctrl.sv
// Bench for mic1_board_ctrl: cycle-level behavioural model with per-cycle compare,
// plus directed scenarios with hand-computed literal expectations.
module tb_mic1_board_ctrl;

  localparam int DEB  = 4;
  localparam int POR  = 8;
  localparam int STEP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  btn_n = 3'b111;
  logic [31:0] out_word = 32'hA5C3_5A96;
  logic [4:0]  led_lsb = 5'd0;
  logic        soc_resetn, run, halted, ledr_n, ledg_n;
  logic [2:0]  btn_press;
  logic [4:0]  led;

  mic1_board_ctrl #(
    .NUM_BTN(3), .DEBOUNCE_CYCLES(DEB), .POR_CYCLES(POR), .STEP_CYCLES(STEP),
    .RUN_ON_RESET(1), .OUT_WIDTH(32), .NUM_LED(5), .LSB_W(5)
  ) dut (
    .clk(clk), .reset(rst), .btn_n(btn_n), .out_word(out_word), .led_lsb(led_lsb),
    .soc_resetn(soc_resetn), .run(run), .halted(halted), .btn_press(btn_press),
    .led(led), .ledr_n(ledr_n), .ledg_n(ledg_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state (mode: 0 reset, 1 run, 2 halt, 3 step)
  int         m_mode, m_left, m_por;
  int         m_len [3];
  logic [2:0] m_acc, m_dly1, m_dly2, m_press;
  logic       m_resetn, m_run, m_halted, m_ready = 1'b0;
  logic [4:0] m_led;

  task automatic model_step();
    logic [2:0] sample, old_press, old_acc;
    logic       old_resetn;
    int         idx;
    if (rst) begin
      m_mode = 0; m_left = 0; m_por = 0;
      for (int b = 0; b < 3; b++) m_len[b] = 0;
      m_acc = '0; m_dly1 = '0; m_dly2 = '0; m_press = '0;
      m_resetn = 1'b0; m_run = 1'b0; m_halted = 1'b0; m_led = '0;
      m_ready = 1'b1;
      return;
    end
    old_press  = m_press;
    old_resetn = m_resetn;
    old_acc    = m_acc;
    if (!old_resetn) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (old_press[1]) m_mode = 2;
        2: if (old_press[1]) m_mode = 1;
           else if (old_press[2]) begin m_mode = 3; m_left = STEP; end
        default: begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 2;
        end
      endcase
    end
    m_run    = (m_mode == 1) || (m_mode == 3);
    m_halted = (m_mode == 2);
    if (old_acc[0]) m_por = 0;
    else if (m_por < POR) m_por = m_por + 1;
    m_resetn = (m_por == POR);
    // Pin level seen two clocks late; accept after DEB consecutive differing samples
    sample = m_dly2;
    m_dly2 = m_dly1;
    m_dly1 = ~btn_n;
    for (int b = 0; b < 3; b++) begin
      m_press[b] = 1'b0;
      if (sample[b] != m_acc[b]) m_len[b] = m_len[b] + 1;
      else m_len[b] = 0;
      if (m_len[b] == DEB) begin
        m_acc[b]   = sample[b];
        m_press[b] = sample[b];
        m_len[b]   = 0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      idx = int'(led_lsb) + i;
      m_led[i] = (idx < 32) ? out_word[idx] : 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (m_ready) begin
      check("soc_resetn", 32'(soc_resetn), 32'(m_resetn));
      check("run", 32'(run), 32'(m_run));
      check("halted", 32'(halted), 32'(m_halted));
      check("btn_press", 32'(btn_press), 32'(m_press));
      check("led", 32'(led), 32'(m_led));
      check("ledr_n", 32'(ledr_n), 32'(m_run));
      check("ledg_n", 32'(ledg_n), 32'(!m_run));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(3);
    check("rst_soc_resetn", 32'(soc_resetn), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_ledr_n", 32'(ledr_n), 32'd0);
    check("rst_ledg_n", 32'(ledg_n), 32'd1);
    check("rst_led", 32'(led), 32'd0);
    rst = 1'b0;

    tick(7);
    check("por_early", 32'(soc_resetn), 32'd0);
    tick(1);
    check("por_rise", 32'(soc_resetn), 32'd1);
    check("por_run_lag", 32'(run), 32'd0);
    tick(1);
    check("run_after_por", 32'(run), 32'd1);
    check("ledg_on", 32'(ledg_n), 32'd0);

    // 3-cycle glitch on button 1
    btn_n[1] = 1'b0;
    tick(3);
    btn_n[1] = 1'b1;
    tick(8);
    check("glitch_run", 32'(run), 32'd1);

    // Real press on button 1 -> HALT
    btn_n[1] = 1'b0;
    tick(5);
    check("press_early", 32'(btn_press), 32'd0);
    tick(1);
    check("press_pulse", 32'(btn_press), 32'b010);
    check("press_run_still", 32'(run), 32'd1);
    tick(1);
    check("press_pulse_end", 32'(btn_press), 32'd0);
    check("halt_run", 32'(run), 32'd0);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_ledr", 32'(ledr_n), 32'd0);
    tick(3);
    btn_n[1] = 1'b1;
    tick(10);

    // Single step from HALT
    btn_n[2] = 1'b0;
    tick(6);
    check("step_press", 32'(btn_press), 32'b100);
    tick(1);
    check("step_run1", 32'(run), 32'd1);
    check("step_halted1", 32'(halted), 32'd0);
    tick(1);
    check("step_run2", 32'(run), 32'd1);
    tick(1);
    check("step_done_run", 32'(run), 32'd0);
    check("step_done_halt", 32'(halted), 32'd1);
    btn_n[2] = 1'b1;
    tick(10);

    // Buttons 1 and 2 together in HALT -> RUN, no step
    btn_n = 3'b001;
    tick(7);
    check("both_run", 32'(run), 32'd1);
    check("both_halted", 32'(halted), 32'd0);
    tick(3);
    check("both_stay_run", 32'(run), 32'd1);
    btn_n = 3'b111;
    tick(10);

    // Step button ignored in RUN
    btn_n[2] = 1'b0;
    tick(10);
    check("step_in_run", 32'(run), 32'd1);
    btn_n[2] = 1'b1;
    tick(10);

    btn_n[1] = 1'b0;
    tick(8);
    btn_n[1] = 1'b1;
    tick(10);
    check("rehalt", 32'(halted), 32'd1);

    // Button 0 lands during the step and aborts it
    btn_n = 3'b010;
    tick(7);
    check("abort_step_run", 32'(run), 32'd1);
    check("abort_resetn", 32'(soc_resetn), 32'd0);
    tick(1);
    check("abort_run", 32'(run), 32'd0);
    check("abort_halted", 32'(halted), 32'd0);
    tick(2);
    btn_n = 3'b111;
    tick(13);
    check("repor_early", 32'(soc_resetn), 32'd0);
    tick(1);
    check("repor_rise", 32'(soc_resetn), 32'd1);
    tick(1);
    check("repor_run", 32'(run), 32'd1);

    // LED window
    out_word = 32'h001F_0000;
    led_lsb  = 5'd16;
    tick(1);
    check("led_mid", 32'(led), 32'h1F);
    led_lsb = 5'd30;
    tick(1);
    check("led_top_zero", 32'(led), 32'h00);
    out_word = 32'hC000_0000;
    tick(1);
    check("led_top_clip", 32'(led), 32'h03);
    repeat (20) begin
      out_word = $urandom;
      led_lsb  = 5'($urandom_range(0, 31));
      tick(1);
    end
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
